// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives valid/data, the slave answers with ready.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 110
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshakes, flush and optional 2-entry skid (PIPE_SKID_EN).
// Latency 1 cycle; with PIPE_SKID_EN up.ready is registered (!skid full), otherwise up.ready = !dn.valid | dn.ready.
module pipe_stage_skid #(
    parameter int                DATA_W   = 110,
    parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    pipe_stage_skid_if.slave        up,
    pipe_stage_skid_if.master       dn,
    output logic [1:0]              occ_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] main_q;
    logic              main_vld;
    logic              up_acc;
    logic              dn_rel;

    assign main_vld = (state_q != S_EMPTY);
    assign up_acc   = up.valid & up.ready;
    assign dn_rel   = dn.valid & dn.ready;
    assign dn.valid = main_vld;
    assign dn.data  = main_vld ? main_q : NOP_DATA;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q;

    // Ready depends only on state, so no combinational path from dn.ready.
    assign up.ready = (state_q != S_FULL);
    assign occ_o    = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= NOP_DATA;
            skid_q  <= NOP_DATA;
        end else if (flush_i) begin
            state_q <= S_EMPTY;
            main_q  <= NOP_DATA;
            skid_q  <= NOP_DATA;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (up_acc) begin
                        main_q  <= up.data;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (up_acc && dn_rel) begin
                        main_q  <= up.data;
                    end else if (up_acc) begin
                        skid_q  <= up.data;
                        state_q <= S_FULL;
                    end else if (dn_rel) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (dn_rel) begin
                        main_q  <= skid_q;
                        state_q <= S_ONE;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end
`else
    // Single register: a new payload may enter in the same cycle the held one leaves.
    assign up.ready = ~main_vld | dn.ready;
    assign occ_o    = {1'b0, main_vld};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= NOP_DATA;
        end else if (flush_i) begin
            state_q <= S_EMPTY;
            main_q  <= NOP_DATA;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (up_acc) begin
                        main_q  <= up.data;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (up_acc) begin
                        main_q  <= up.data;
                    end else if (dn_rel) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised self-checking bench for pipe_stage_skid (either PIPE_SKID_EN setting).
module tb_pipe_stage_skid;

    localparam int DW = 110;
    typedef logic [DW-1:0] data_t;
    localparam data_t NOPV = 110'h1BAD_C0DE;

`ifdef PIPE_SKID_EN
    localparam int MAXOCC = 2;
`else
    localparam int MAXOCC = 1;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occ;

    pipe_stage_skid_if #(.DATA_W(DW)) up_if ();
    pipe_stage_skid_if #(.DATA_W(DW)) dn_if ();

    pipe_stage_skid #(.DATA_W(DW), .NOP_DATA(NOPV)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .up      (up_if),
        .dn      (dn_if),
        .occ_o   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input data_t got, input data_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input data_t d, input int o);
        chk({tag, "_vld"}, data_t'(dn_if.valid), data_t'(v));
        chk({tag, "_dat"}, dn_if.data, d);
        chk({tag, "_occ"}, data_t'(occ), data_t'(o));
    endtask

    data_t q[$];
    data_t exp_d;
    data_t prev_d;
    logic  acc, rel, stall;
    int    seq;

    initial begin
        rst = 1'b0; flush = 1'b0;
        up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;
        #3;
        chk_out("reset", 1'b0, NOPV, 0);
        chk("reset_rdy", data_t'(up_if.ready), data_t'(1'b1));
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Streaming with downstream always ready.
        up_if.valid = 1'b1; dn_if.ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            up_if.data = data_t'(i);
            cyc();
            chk_out($sformatf("stream%0d", i), 1'b1, data_t'(i), 1);
        end
        up_if.valid = 1'b0;
        cyc();
        chk_out("stream_drain", 1'b0, NOPV, 0);

        // Backpressure: A then B offered while downstream stalls.
        dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = data_t'('hA);
        cyc();
        chk_out("bp_a", 1'b1, data_t'('hA), 1);
        up_if.data = data_t'('hB);
        cyc();
        chk_out("bp_b", 1'b1, data_t'('hA), MAXOCC);
        chk("bp_rdy", data_t'(up_if.ready), data_t'(1'b0));
        cyc();
        chk_out("bp_hold", 1'b1, data_t'('hA), MAXOCC);
        dn_if.ready = 1'b1;
        cyc();
        chk_out("bp_relA", 1'b1, data_t'('hB), 1);
        up_if.valid = 1'b0;
        cyc();
        chk_out("bp_relB", 1'b0, NOPV, 0);

        // Flush at maximum occupancy with C offered concurrently.
        dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = data_t'('hA);
        cyc();
        up_if.data = data_t'('hB);
        cyc();
        chk("fl_pre_occ", data_t'(occ), data_t'(MAXOCC));
        up_if.data = data_t'('hC); flush = 1'b1;
        cyc();
        chk_out("flush", 1'b0, NOPV, 0);
        chk("flush_rdy", data_t'(up_if.ready), data_t'(1'b1));
        flush = 1'b0; up_if.valid = 1'b0; dn_if.ready = 1'b1;
        cyc();
        chk_out("flush_noC", 1'b0, NOPV, 0);

        // Flush with a concurrent release and accept while holding one entry.
        up_if.valid = 1'b1; up_if.data = data_t'('hD); dn_if.ready = 1'b0;
        cyc();
        up_if.data = data_t'('hE); dn_if.ready = 1'b1; flush = 1'b1;
        cyc();
        chk_out("flush1", 1'b0, NOPV, 0);
        flush = 1'b0; up_if.valid = 1'b0;
        cyc();
        chk_out("flush1_noE", 1'b0, NOPV, 0);

        // Asynchronous reset mid-stream.
        dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = data_t'('h11);
        cyc();
        up_if.data = data_t'('h12);
        cyc();
        rst = 1'b0;
        #1;
        chk_out("arst", 1'b0, NOPV, 0);
        up_if.valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_rdy", data_t'(up_if.ready), data_t'(1'b1));
        cyc();
        chk_out("arst_after", 1'b0, NOPV, 0);

        // Random valid/ready against a queue scoreboard.
        seq = 1;
        for (int c = 0; c < 3000; c++) begin
            up_if.valid = 1'($urandom_range(0, 1));
            up_if.data  = (data_t'(1) << 100) | (data_t'($urandom) << 32) | data_t'(seq);
            dn_if.ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            if (c % 500 < 100) dn_if.ready = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            #1;
`ifdef PIPE_SKID_EN
            exp_d = data_t'(q.size() < 2);
`else
            exp_d = data_t'(q.size() == 0 || dn_if.ready);
`endif
            chk("rnd_rdy", data_t'(up_if.ready), exp_d);
            acc    = up_if.valid & up_if.ready;
            rel    = dn_if.valid & dn_if.ready;
            stall  = dn_if.valid & ~dn_if.ready;
            prev_d = dn_if.data;
            cyc();
            if (rel && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(up_if.data);
                seq++;
            end
            chk("rnd_occ", data_t'(occ), data_t'(q.size()));
            if (q.size() > 0) chk("rnd_dat", dn_if.data, q[0]);
            else              chk("rnd_nop", dn_if.data, NOPV);
            if (stall) chk("rnd_stable", dn_if.data, prev_d);
            if (int'(occ) > MAXOCC) chk("rnd_maxocc", data_t'(occ), data_t'(MAXOCC));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
